// File: rtl/hack_alu_mul_seq_if.sv
// rtl/hack_alu_mul_seq_if.sv - valid/ready operand and result bundle for hack_alu_mul_seq
interface hack_alu_mul_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zr;
  logic        ng;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, zr, ng, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, zr, ng, busy
  );
endinterface

// File: rtl/hack_alu_mul_seq.sv
// rtl/hack_alu_mul_seq.sv - shift-add 16x16 multiply sequencer on one HackALU
// Optional HACK_MUL_EARLY_EXIT_EN: stop once no set multiplier bits remain.
module hack_alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out
);
  logic [15:0] xz, xn, yz, yn, fo;

  always_comb begin
    xz  = zx ? 16'h0000 : x;
    xn  = nx ? ~xz : xz;
    yz  = zy ? 16'h0000 : y;
    yn  = ny ? ~yz : yz;
    fo  = f ? (xn + yn) : (xn & yn);
    out = no ? ~fo : fo;
  end
endmodule

module hack_alu_mul_seq #(
  parameter int N_BITS = 16
) (
  input logic                clk,
  input logic                rst,
  hack_alu_mul_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ADD, DBL, DONE} state_t;

  localparam logic [15:0] MASK     = 16'((32'd1 << N_BITS) - 32'd1);
  localparam logic [3:0]  CNT_LAST = 4'(N_BITS - 1);

  state_t      state;
  logic [15:0] acc, mcand, mplier;
  logic [3:0]  cnt;
  logic        in_ready_q, out_valid_q, busy_q, zr_q, ng_q;
  logic [15:0] result_q;
  logic [15:0] alu_x, alu_out;
  logic        dbl_exit;
  logic [15:0] b_used;

  // Both ALU cycles are plain additions; only the x operand changes.
  assign alu_x  = (state == DBL) ? mcand : acc;
  assign b_used = bus.b & MASK;

  hack_alu u_alu (
    .x  (alu_x),
    .y  (mcand),
    .zx (1'b0),
    .nx (1'b0),
    .zy (1'b0),
    .ny (1'b0),
    .f  (1'b1),
    .no (1'b0),
    .out(alu_out)
  );

`ifdef HACK_MUL_EARLY_EXIT_EN
  assign dbl_exit = (cnt == CNT_LAST) || (mplier[15:1] == 15'd0);
`else
  assign dbl_exit = (cnt == CNT_LAST);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= 16'h0000;
      mcand       <= 16'h0000;
      mplier      <= 16'h0000;
      cnt         <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= 16'h0000;
      zr_q        <= 1'b1;
      ng_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand      <= bus.a;
            mplier     <= b_used;
            acc        <= 16'h0000;
            cnt        <= 4'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef HACK_MUL_EARLY_EXIT_EN
            // Zero multiplier skips ADD; the lone DBL cycle exits at once with acc=0.
            state      <= (b_used == 16'h0000) ? DBL : ADD;
`else
            state      <= ADD;
`endif
          end
        end
        ADD: begin
          if (mplier[0]) acc <= alu_out;
          state <= DBL;
        end
        DBL: begin
          mcand  <= alu_out;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
          if (dbl_exit) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= acc;
            zr_q        <= (acc == 16'h0000);
            ng_q        <= acc[15];
          end else begin
            state <= ADD;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;
endmodule

// File: tb/tb_hack_alu_mul_seq.sv
// tb/tb_hack_alu_mul_seq.sv - self-checking bench for hack_alu_mul_seq
module tb_hack_alu_mul_seq;
  logic clk = 1'b0;
  logic rst;
  int   ncmp = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  hack_alu_mul_seq_if bus ();

  hack_alu_mul_seq dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    return p[15:0];
  endfunction

  function automatic int ref_lat(input logic [15:0] b);
`ifdef HACK_MUL_EARLY_EXIT_EN
    int k;
    k = -1;
    for (int i = 0; i < 16; i++) if (b[i]) k = i;
    return (k < 0) ? 1 : 2 * (k + 1);
`else
    return 32;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input int hold);
    logic [15:0] er;
    int lat;
    er = ref_mul(a, b);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(ref_lat(b)));
    check({tag, "_result"}, 32'(bus.result), 32'(er));
    check({tag, "_zr"}, 32'(bus.zr), 32'(er == 16'h0000));
    check({tag, "_ng"}, 32'(bus.ng), 32'(er[15]));
    for (int i = 0; i < hold; i++) begin
      if (i == 2) begin
        bus.a = 16'h00AA;
        bus.b = 16'h0055;
        bus.in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_result"}, 32'(bus.result), 32'(er));
      check({tag, "_hold_zr"}, 32'(bus.zr), 32'(er == 16'h0000));
      check({tag, "_hold_ng"}, 32'(bus.ng), 32'(er[15]));
      check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_idle_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_idle_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = 16'h0000;
    bus.b = 16'h0000;
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_zr", 32'(bus.zr), 32'd1);
    check("rst_ng", 32'(bus.ng), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("3x5", 16'd3, 16'd5, 0);
    run_op("b_zero", 16'h1234, 16'h0000, 0);
    run_op("neg1sq", 16'hFFFF, 16'hFFFF, 0);
    run_op("wrap0", 16'h0100, 16'h0100, 0);
    run_op("hold_7xm3", 16'd7, 16'hFFFD, 5);

    for (int n = 0; n < 16; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom) >> $urandom_range(0, 15);
      run_op("rand", ra, rb, (n % 4 == 0) ? 3 : 0);
    end

    @(negedge clk);
    bus.a = 16'd9;
    bus.b = 16'hFFFF;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_zr", 32'(bus.zr), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_abort_6x7", 16'd6, 16'd7, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
